// File: rtl/inst_fetch_pkg.sv
// Shared MIPS controller definitions: next-PC selector encodings and fetch helpers.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_JUMP   = 2'd1,
    PC_JR     = 2'd2,
    PC_BRANCH = 2'd3
  } pc_src_e;

  localparam logic [31:0] INST_BYTES = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-request memory interface, delayed redirects,
// exception redirect with in-flight kill, one-word hold buffer for ID back-pressure.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic        id_valid,
  input  logic [1:0]  pc_src,
  input  logic [31:0] target_jump,
  input  logic [31:0] target_jr,
  input  logic [31:0] target_branch,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        adr_err,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] hold_q, hold_d;
  logic        req_out_q, req_out_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        adr_err_q, adr_err_d;

  logic        redirect;
  logic        pc_update;
  logic [31:0] redir_target;

  assign redirect = id_valid && (pc_src_e'(pc_src) != PC_NEXT);

  always_comb begin
    case (pc_src_e'(pc_src))
      PC_JR:     redir_target = target_jr;
      PC_BRANCH: redir_target = target_branch;
      default:   redir_target = target_jump;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    kill_addr_d   = kill_addr_q;
    hold_d        = hold_q;
    req_out_d     = 1'b0;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    adr_err_d     = adr_err_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    pc_update     = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (is_misaligned(pc_q)) begin
          if (if_en) begin
            inst_d       = '0;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            adr_err_d    = 1'b1;
          end
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (if_en) begin
              inst_d       = imem_data;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              adr_err_d    = 1'b0;
              pc_update    = 1'b1;
            end else begin
              hold_d  = imem_data;
              state_d = HOLD;
            end
          end else begin
            req_out_d = 1'b1;
            if (if_en) begin
              inst_valid_d = 1'b0;
              adr_err_d    = 1'b0;
            end
          end
        end
      end
      HOLD: begin
        if (if_en) begin
          inst_d       = hold_q;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          adr_err_d    = 1'b0;
          pc_update    = 1'b1;
          state_d      = FETCH;
        end
      end
      KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr_q;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // A redirect seen in the same cycle as the PC update bypasses the pending register.
    if (pc_update) begin
      pc_d         = redirect ? redir_target
                   : (pend_valid_q ? pend_target_q : pc_q + INST_BYTES);
      pend_valid_d = 1'b0;
    end else if (redirect) begin
      pend_target_d = redir_target;
      pend_valid_d  = 1'b1;
    end

    // Exceptions override everything; an unacked request already on the bus must drain in KILL.
    if (exc_valid) begin
      pc_d         = exc_target;
      pend_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = 1'b0;
      adr_err_d    = 1'b0;
      req_out_d    = 1'b0;
      if (!imem_ack && ((state_q == FETCH && req_out_q) || state_q == KILL)) begin
        state_d = KILL;
        if (state_q == FETCH) kill_addr_d = pc_q;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      kill_addr_q   <= '0;
      hold_q        <= '0;
      req_out_q     <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      adr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      kill_addr_q   <= kill_addr_d;
      hold_q        <= hold_d;
      req_out_q     <= req_out_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      adr_err_q     <= adr_err_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign adr_err    = adr_err_q;
  assign stall_req  = !inst_valid_q && (state_q != HOLD);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences,
// and a randomized run checked against a program-order PC model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_en = 1'b0, id_valid = 1'b0, exc_valid = 1'b0, imem_ack = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] target_jump = '0, target_jr = '0, target_branch = '0;
  logic [31:0] exc_target = '0, imem_data = '0;
  logic        imem_req, inst_valid, adr_err, stall_req;
  logic [31:0] imem_addr, inst, inst_pc;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .if_en(if_en), .id_valid(id_valid), .pc_src(pc_src),
    .target_jump(target_jump), .target_jr(target_jr), .target_branch(target_branch),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .adr_err(adr_err),
    .stall_req(stall_req)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_targets(input logic [31:0] t);
    target_branch = t;
    target_jump   = t ^ 32'h0000_1000;
    target_jr     = t ^ 32'h0000_2000;
  endtask

  task automatic quiet_inputs();
    if_en = 1'b1; id_valid = 1'b0; pc_src = PC_NEXT; exc_valid = 1'b0;
    exc_target = '0; imem_ack = 1'b0; imem_data = '0; set_targets('0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   imem_req,   0);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_inst"},  inst,       0);
    chk({tag, "_pc"},    inst_pc,    0);
    chk({tag, "_aerr"},  adr_err,    0);
    chk({tag, "_stall"}, stall_req,  1);
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    repeat (2) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
  endtask

  typedef struct {
    logic        if_en;
    logic        ack;
    logic [31:0] data;
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_stall;
  } vec_t;

  function automatic vec_t mkv(input logic en, input logic ack, input logic [31:0] data,
                               input logic redir, input logic [31:0] tgt,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc,
                               input logic e_stall);
    vec_t v;
    v.if_en = en; v.ack = ack; v.data = data; v.redir = redir; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_inst = mem_word(e_pc); v.e_stall = e_stall;
    return v;
  endfunction

  vec_t vt[14];

  // random-phase state
  logic [31:0] exp_next, pend_t, mem_addr, tgt;
  logic        pend_ok, mem_pending;
  int unsigned mem_lat, deliveries;
  logic        p_if_en, p_exc, p_redir, p_req, p_ack, p_valid;
  logic [31:0] p_exc_t, p_redir_t, p_addr, p_inst, p_pc;

  initial begin
    // Sequential stream, branch in delay slot, and a 4-cycle ID back-pressure hold.
    vt[0]  = mkv(1, 1, 32'hDEAD_BEEF, 0, 0,        1, 32'h0,   0, 32'h0,  1);
    vt[1]  = mkv(1, 1, mem_word(0),   0, 0,        1, 32'h4,   1, 32'h0,  0);
    vt[2]  = mkv(1, 1, mem_word(4),   0, 0,        1, 32'h8,   1, 32'h4,  0);
    vt[3]  = mkv(1, 1, mem_word(8),   0, 0,        1, 32'hC,   1, 32'h8,  0);
    vt[4]  = mkv(1, 1, mem_word(12),  0, 0,        1, 32'h10,  1, 32'hC,  0);
    vt[5]  = mkv(1, 1, mem_word(16),  0, 0,        1, 32'h14,  1, 32'h10, 0);
    vt[6]  = mkv(1, 1, mem_word(20),  1, 32'h100,  1, 32'h100, 1, 32'h14, 0);
    vt[7]  = mkv(0, 1, mem_word(256), 0, 0,        0, 32'h0,   1, 32'h14, 0);
    vt[8]  = mkv(0, 0, 32'h0,         0, 0,        0, 32'h0,   1, 32'h14, 0);
    vt[9]  = mkv(0, 0, 32'h0,         0, 0,        0, 32'h0,   1, 32'h14, 0);
    vt[10] = mkv(0, 0, 32'h0,         0, 0,        0, 32'h0,   1, 32'h14, 0);
    vt[11] = mkv(1, 0, 32'h0,         0, 0,        1, 32'h104, 1, 32'h100, 0);
    vt[12] = mkv(1, 0, 32'h0,         0, 0,        1, 32'h104, 0, 32'h0,  1);
    vt[13] = mkv(1, 1, mem_word(260), 0, 0,        1, 32'h108, 1, 32'h104, 0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      quiet_inputs();
      if_en = vt[i].if_en; imem_ack = vt[i].ack; imem_data = vt[i].data;
      id_valid = vt[i].redir; pc_src = vt[i].redir ? PC_BRANCH : PC_NEXT;
      set_targets(vt[i].tgt);
      tick();
      chk($sformatf("vec%0d_req", i),   imem_req,   vt[i].e_req);
      chk($sformatf("vec%0d_valid", i), inst_valid, vt[i].e_valid);
      chk($sformatf("vec%0d_stall", i), stall_req,  vt[i].e_stall);
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i),   inst_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_inst", i), inst,    vt[i].e_inst);
      end
    end

    // Exception with an unacked request in flight: the old word must drain and be dropped.
    do_reset();
    quiet_inputs(); tick();
    exc_valid = 1; exc_target = 32'h20; tick();
    chk("exc_issue_addr", {imem_req, imem_addr}, {1'b1, 32'h20});
    exc_valid = 0; tick();
    exc_valid = 1; exc_target = 32'h180; tick();
    exc_valid = 0;
    chk("kill_addr0", {imem_req, imem_addr}, {1'b1, 32'h20});
    chk("kill_valid0", inst_valid, 0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk($sformatf("kill_addr%0d", k), {imem_req, imem_addr}, {1'b1, 32'h20});
      chk($sformatf("kill_valid%0d", k), inst_valid, 0);
    end
    imem_ack = 1; imem_data = mem_word(32'h20); tick();
    chk("kill_done_addr", {imem_req, imem_addr}, {1'b1, 32'h180});
    chk("kill_done_valid", inst_valid, 0);
    imem_data = mem_word(32'h180); tick();
    chk("exc_deliver", {inst_valid, inst_pc, inst}, {1'b1, 32'h180, mem_word(32'h180)});
    chk("exc_next_addr", imem_addr, 32'h184);

    // Misaligned exception target: no fetch, address-error NOP, PC frozen.
    imem_ack = 0; exc_valid = 1; exc_target = 32'h202; tick();
    exc_valid = 0;
    chk("mis_req0", imem_req, 0);
    chk("mis_stall0", stall_req, 1);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk($sformatf("mis_req%0d", k), imem_req, 0);
      chk($sformatf("mis_out%0d", k), {inst_valid, adr_err, inst, inst_pc},
          {1'b1, 1'b1, 32'h0, 32'h202});
      chk($sformatf("mis_stall%0d", k), stall_req, 0);
    end

    // Top-of-memory wrap of pc+4.
    exc_valid = 1; exc_target = 32'hFFFF_FFFC; tick();
    exc_valid = 0;
    chk("wrap_addr", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
    chk("wrap_aerr", adr_err, 0);
    imem_ack = 1; imem_data = mem_word(32'hFFFF_FFFC); tick();
    chk("wrap_next", imem_addr, 32'h0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of an outstanding request.
    imem_ack = 0; tick();
    #2 rst = 0; imem_ack = 1; imem_data = 32'h1234_5678;
    #1 chk_reset_outputs("async_rst");
    repeat (2) tick();
    chk("rst_hold_req", imem_req, 0);
    rst = 1; tick();
    chk("restart_addr", {imem_req, imem_addr, inst_valid}, {1'b1, 32'h0, 1'b0});
    imem_data = mem_word(0); tick();
    chk("restart_deliver", {inst_valid, inst_pc, inst}, {1'b1, 32'h0, mem_word(0)});

    // Randomized run: deliveries must follow program order with delayed redirects.
    do_reset();
    exp_next = 32'h0; pend_ok = 0; pend_t = '0; mem_pending = 0; mem_addr = '0;
    mem_lat = 0; deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      if_en      = ($urandom_range(0, 3) != 0);
      exc_valid  = ($urandom_range(0, 39) == 0);
      exc_target = 32'($urandom_range(0, 255)) << 2;
      id_valid   = ($urandom_range(0, 9) == 0);
      pc_src     = 2'($urandom_range(0, 3));
      tgt        = 32'($urandom_range(64, 511)) << 2;
      set_targets(tgt);
      if (imem_req) begin
        if (!mem_pending || imem_addr != mem_addr) begin
          mem_addr = imem_addr;
          mem_lat  = $urandom_range(0, 2);
        end
        imem_ack    = (mem_lat == 0);
        imem_data   = imem_ack ? mem_word(imem_addr) : $urandom;
        mem_pending = !imem_ack;
        if (mem_lat != 0) mem_lat--;
      end else begin
        imem_ack    = ($urandom_range(0, 7) == 0);
        imem_data   = $urandom;
        mem_pending = 0;
      end
      p_if_en = if_en; p_exc = exc_valid; p_exc_t = exc_target;
      p_redir = id_valid && (pc_src != PC_NEXT);
      case (pc_src)
        2'd1:    p_redir_t = tgt ^ 32'h0000_1000;
        2'd2:    p_redir_t = tgt ^ 32'h0000_2000;
        default: p_redir_t = tgt;
      endcase
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_valid = inst_valid; p_inst = inst; p_pc = inst_pc;
      tick();
      if (p_exc) begin
        exp_next = p_exc_t;
        pend_ok  = 0;
        chk("rnd_exc_flush", inst_valid, 0);
      end else begin
        if (p_redir) begin
          pend_ok = 1;
          pend_t  = p_redir_t;
        end
        if (!p_if_en) begin
          chk("rnd_hold", {inst_valid, inst, inst_pc}, {p_valid, p_inst, p_pc});
        end else if (inst_valid) begin
          chk("rnd_order", inst_pc, exp_next);
          chk("rnd_data", inst, mem_word(exp_next));
          chk("rnd_aerr", adr_err, 0);
          exp_next = pend_ok ? pend_t : exp_next + 32'd4;
          pend_ok  = 0;
          deliveries++;
        end
        if (p_req && !p_ack) chk("rnd_addr_stable", {imem_req, imem_addr}, {1'b1, p_addr});
      end
      if (imem_req) chk("rnd_addr_align", imem_addr[1:0], 0);
      if (inst_valid) chk("rnd_stall", stall_req, 0);
    end
    chk("rnd_progress", deliveries > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
